hamming74_codec: RTL and testbench
==================================

# hamming74_codec

Hamming(7,4) codec with free-running 3-bit counter for the UART link. Encoder turns 4-bit nibbles into 7-bit single-error-correcting codewords for the transmitter. Decoder corrects received 7-bit codewords and reports syndrome and corrected-error count. Counter drives the TX debug state field.

## Interface
- No parameters; widths fixed (data 4, code 7, syndrome 3, counters 3).
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  reset; synchronous and active-high.
- enc_ena  in  1  encode request; sample enc_data_in this cycle.
- enc_data_in  in  4  data nibble d[3:0].
- enc_code_out  out  7  registered codeword.
- enc_valid_out  out  1  codeword produced from previous-cycle request.
- dec_ena  in  1  decode request; sample dec_code_in this cycle.
- dec_code_in  in  7  received codeword.
- dec_data_out  out  4  corrected data nibble.
- dec_syndrome_out  out  3  syndrome of last decoded word.
- dec_err_count  out  3  corrected-error count, mod 8.
- dec_valid_out  out  1  decode result valid.
- cnt_ena  in  1  counter increment enable.
- cnt_count  out  3  counter value.
- cnt_done  out  1  high while cnt_count == 7.

## Operation
- Codeword bit i is Hamming position i+1: code[0]=p1, code[1]=p2, code[2]=d0, code[3]=p4, code[4]=d1, code[5]=d2, code[6]=d3.
- Parity: p1=d0^d1^d3; p2=d0^d2^d3; p4=d1^d2^d3.
- Syndrome {s4,s2,s1}:
  - s1 = XOR of positions 1,3,5,7.
  - s2 = XOR of positions 2,3,6,7.
  - s4 = XOR of positions 4,5,6,7.
- Syndrome value is the position of the erroneous bit.
- Decoder behaviour:
  - Syndrome 0: no correction.
  - Syndrome k≠0: invert code bit k-1 before extracting data; increment dec_err_count, wrapping 7→0.
  - Double-bit errors are not detected. They are miscorrected per syndrome; no flag.
- Encoder with enc_ena low: enc_code_out holds last value; enc_valid_out=0.
- Decoder with dec_ena low: dec_data_out, dec_syndrome_out and dec_err_count hold; dec_valid_out=0.
- Counter:
  - Increments by 1 each cycle cnt_ena=1; wraps 7→0; holds when cnt_ena=0.
  - cnt_done is combinational from cnt_count.

## Timing
- All state registered on rising clk edge.
- rst wins over every enable.
- Reset value of every output is 0: code, valid, data, syndrome, err count, count. cnt_done=0 after reset.
- Encoder latency 1 cycle: request in cycle N gives code and valid=1 in cycle N+1.
  - valid is a single-cycle pulse per request cycle.
  - Back-to-back requests give back-to-back valid pulses with a new code each cycle.
- Decoder latency 1 cycle: same rule. dec_err_count updates in the same edge as dec_data_out.
- Encoder, decoder and counter are independent. Simultaneous enables are all serviced in the same cycle.
- rst asserted mid-stream: next edge clears everything. Any pending valid pulse is dropped.

## Structure
- Package hamming74_pkg holds:
  - Width constants: DATA_W=4, CODE_W=7, SYN_W=3.
  - Pure functions hamming74_encode(d) and hamming74_syndrome(c).
  - Bit-position constants for p1/p2/d0/p4/d1/d2/d3.
- Encoder and decoder datapaths are inline in the top, using the package functions.
- One sub-module is natural: mod8_counter (enable, count, done). It is reused for cnt_count.
- dec_err_count uses inline increment logic.

## Test plan
- Reset: hold rst 2 cycles with all enables high -> every output 0, valids 0.
- Encode: enc_data_in=4'hB, enc_ena 1 cycle -> next cycle enc_code_out=7'h55, enc_valid_out=1; cycle after, valid=0 and code still 7'h55.
- Encode corners: data 4'h0 -> 7'h00; data 4'hF -> 7'h7F. Issue them back-to-back -> two consecutive valid pulses.
- Decode clean: dec_code_in=7'h55 -> dec_data_out=4'hB, syndrome=0, err count unchanged.
- Decode single error: dec_code_in=7'h45 (bit 4 flipped) -> data=4'hB, syndrome=3'd5, err count +1. Sweep all 16 nibbles × 7 single-bit flips -> always correct data, syndrome = flipped index+1.
- Counter: cnt_ena high 9 cycles from reset -> counts 1..7,0,1; cnt_done high only while count=7. Drop cnt_ena -> count holds. Assert rst at count 5 -> 0 next cycle.

Source files
------------

// File: rtl/hamming74_pkg.sv
// Shared widths, codeword bit positions and pure Hamming(7,4) helpers.
package hamming74_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CODE_W = 7;
  localparam int unsigned SYN_W  = 3;
  localparam int unsigned CNT_W  = 3;

  // Codeword bit index = Hamming position - 1
  localparam int unsigned POS_P1 = 0;
  localparam int unsigned POS_P2 = 1;
  localparam int unsigned POS_D0 = 2;
  localparam int unsigned POS_P4 = 3;
  localparam int unsigned POS_D1 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D3 = 6;

  function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[POS_D0] = d[0];
    c[POS_D1] = d[1];
    c[POS_D2] = d[2];
    c[POS_D3] = d[3];
    c[POS_P1] = d[0] ^ d[1] ^ d[3];
    c[POS_P2] = d[0] ^ d[2] ^ d[3];
    c[POS_P4] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  // Returns {s4,s2,s1}; a nonzero value is the 1-based position of a single flipped bit
  function automatic logic [SYN_W-1:0] hamming74_syndrome(input logic [CODE_W-1:0] c);
    logic s1, s2, s4;
    s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s4, s2, s1};
  endfunction

  function automatic logic [DATA_W-1:0] hamming74_extract(input logic [CODE_W-1:0] c);
    return {c[POS_D3], c[POS_D2], c[POS_D1], c[POS_D0]};
  endfunction

endpackage

// File: rtl/hamming74_codec_mod8_counter.sv
// Free-running modulo-8 counter with enable and terminal-count flag.
module mod8_counter
  import hamming74_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: advance when enabled, natural wrap 7 -> 0
  always_comb begin
    count_d = count_q;
    if (ena) count_d = count_q + CNT_W'(1);
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign done  = (count_q == '1);

endmodule

// File: rtl/hamming74_codec.sv
// Hamming(7,4) encoder/decoder pair plus debug counter for the UART link.
module hamming74_codec
  import hamming74_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_ena,
  input  logic [DATA_W-1:0] enc_data_in,
  output logic [CODE_W-1:0] enc_code_out,
  output logic              enc_valid_out,
  input  logic              dec_ena,
  input  logic [CODE_W-1:0] dec_code_in,
  output logic [DATA_W-1:0] dec_data_out,
  output logic [SYN_W-1:0]  dec_syndrome_out,
  output logic [CNT_W-1:0]  dec_err_count,
  output logic              dec_valid_out,
  input  logic              cnt_ena,
  output logic [CNT_W-1:0]  cnt_count,
  output logic              cnt_done
);

  logic [CODE_W-1:0] enc_code_q, enc_code_d;
  logic              enc_valid_q, enc_valid_d;
  logic [DATA_W-1:0] dec_data_q, dec_data_d;
  logic [SYN_W-1:0]  dec_syn_q, dec_syn_d;
  logic [CNT_W-1:0]  dec_err_q, dec_err_d;
  logic              dec_valid_q, dec_valid_d;

  logic [SYN_W-1:0]  syn;
  logic [CODE_W-1:0] flip_mask;

  // Encoder next state: new codeword on request, otherwise hold code and drop valid
  always_comb begin
    enc_code_d  = enc_code_q;
    enc_valid_d = 1'b0;
    if (enc_ena) begin
      enc_code_d  = hamming74_encode(enc_data_in);
      enc_valid_d = 1'b1;
    end
  end

  // Decoder next state: correct the bit named by the syndrome and count corrections
  always_comb begin
    syn         = hamming74_syndrome(dec_code_in);
    flip_mask   = '0;
    dec_data_d  = dec_data_q;
    dec_syn_d   = dec_syn_q;
    dec_err_d   = dec_err_q;
    dec_valid_d = 1'b0;
    if (syn != '0) flip_mask = CODE_W'(1) << (syn - SYN_W'(1));
    if (dec_ena) begin
      dec_data_d  = hamming74_extract(dec_code_in ^ flip_mask);
      dec_syn_d   = syn;
      dec_valid_d = 1'b1;
      if (syn != '0) dec_err_d = dec_err_q + CNT_W'(1);
    end
  end

  // Encoder/decoder registers; reset overrides every enable
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_code_q  <= '0;
      enc_valid_q <= 1'b0;
      dec_data_q  <= '0;
      dec_syn_q   <= '0;
      dec_err_q   <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      enc_code_q  <= enc_code_d;
      enc_valid_q <= enc_valid_d;
      dec_data_q  <= dec_data_d;
      dec_syn_q   <= dec_syn_d;
      dec_err_q   <= dec_err_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  mod8_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .ena   (cnt_ena),
    .count (cnt_count),
    .done  (cnt_done)
  );

  assign enc_code_out     = enc_code_q;
  assign enc_valid_out    = enc_valid_q;
  assign dec_data_out     = dec_data_q;
  assign dec_syndrome_out = dec_syn_q;
  assign dec_err_count    = dec_err_q;
  assign dec_valid_out    = dec_valid_q;

endmodule

// File: tb/tb_hamming74_codec.sv
// Scoreboard bench for hamming74_codec: expectations queued at drive time, checked after each edge.
module tb_hamming74_codec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_ena = 1'b0;
  logic [3:0] enc_data_in = '0;
  logic [6:0] enc_code_out;
  logic       enc_valid_out;
  logic       dec_ena = 1'b0;
  logic [6:0] dec_code_in = '0;
  logic [3:0] dec_data_out;
  logic [2:0] dec_syndrome_out;
  logic [2:0] dec_err_count;
  logic       dec_valid_out;
  logic       cnt_ena = 1'b0;
  logic [2:0] cnt_count;
  logic       cnt_done;

  hamming74_codec dut (
    .clk              (clk),
    .rst              (rst),
    .enc_ena          (enc_ena),
    .enc_data_in      (enc_data_in),
    .enc_code_out     (enc_code_out),
    .enc_valid_out    (enc_valid_out),
    .dec_ena          (dec_ena),
    .dec_code_in      (dec_code_in),
    .dec_data_out     (dec_data_out),
    .dec_syndrome_out (dec_syndrome_out),
    .dec_err_count    (dec_err_count),
    .dec_valid_out    (dec_valid_out),
    .cnt_ena          (cnt_ena),
    .cnt_count        (cnt_count),
    .cnt_done         (cnt_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] syn;
  } dec_exp_t;

  logic [6:0] enc_exp_q[$];
  dec_exp_t   dec_exp_q[$];

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference state
  logic [6:0] m_code = '0;
  logic [3:0] m_data = '0;
  logic [2:0] m_syn  = '0;
  logic [2:0] m_err  = '0;
  logic [2:0] m_cnt  = '0;
  logic       m_ev   = 1'b0;
  logic       m_dv   = 1'b0;

  // Generic Hamming construction: data fills non-power-of-two positions, parity p covers positions with bit p set
  function automatic logic [6:0] model_encode(input logic [3:0] d);
    logic [6:0]  c;
    int unsigned k;
    logic        par;
    c = '0;
    k = 0;
    for (int unsigned pos = 1; pos <= 7; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int unsigned p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int unsigned pos = 1; pos <= 7; pos++)
        if (((pos & p) != 0) && (pos != p)) par = par ^ c[pos-1];
      c[p-1] = par;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic enc_req(input logic [3:0] d);
    enc_ena     = 1'b1;
    enc_data_in = d;
    enc_exp_q.push_back(model_encode(d));
  endtask

  task automatic dec_req(input logic [6:0] c, input logic [3:0] exp_d, input logic [2:0] exp_s);
    dec_exp_t e;
    dec_ena     = 1'b1;
    dec_code_in = c;
    e.data      = exp_d;
    e.syn       = exp_s;
    dec_exp_q.push_back(e);
  endtask

  // One clock: advance the reference from the inputs seen at the edge, then compare every output
  task automatic step();
    logic r, ee, de, ce;
    dec_exp_t e;
    r  = rst;
    ee = enc_ena;
    de = dec_ena;
    ce = cnt_ena;
    @(posedge clk);
    #1;
    if (r) begin
      enc_exp_q.delete();
      dec_exp_q.delete();
      m_code = '0; m_data = '0; m_syn = '0; m_err = '0; m_cnt = '0;
      m_ev = 1'b0; m_dv = 1'b0;
    end else begin
      m_ev = ee;
      if (ee) begin
        if (enc_exp_q.size() > 0) m_code = enc_exp_q.pop_front();
        else chk("enc_scoreboard_empty", 32'd1, 32'd0);
      end
      m_dv = de;
      if (de) begin
        if (dec_exp_q.size() > 0) begin
          e      = dec_exp_q.pop_front();
          m_data = e.data;
          m_syn  = e.syn;
          if (e.syn != 3'd0) m_err = m_err + 3'd1;
        end else chk("dec_scoreboard_empty", 32'd1, 32'd0);
      end
      if (ce) m_cnt = m_cnt + 3'd1;
    end
    chk("enc_valid", 32'(enc_valid_out), 32'(m_ev));
    chk("enc_code", 32'(enc_code_out), 32'(m_code));
    chk("dec_valid", 32'(dec_valid_out), 32'(m_dv));
    chk("dec_data", 32'(dec_data_out), 32'(m_data));
    chk("dec_syndrome", 32'(dec_syndrome_out), 32'(m_syn));
    chk("dec_err_count", 32'(dec_err_count), 32'(m_err));
    chk("cnt_count", 32'(cnt_count), 32'(m_cnt));
    chk("cnt_done", 32'(cnt_done), 32'(m_cnt == 3'd7));
    enc_ena = 1'b0;
    dec_ena = 1'b0;
  endtask

  initial begin
    logic [6:0] c;

    // Reset for 2 cycles with every enable high
    rst = 1'b1;
    repeat (2) begin
      enc_ena = 1'b1; enc_data_in = 4'hF;
      dec_ena = 1'b1; dec_code_in = 7'h01;
      cnt_ena = 1'b1;
      step();
    end
    rst = 1'b0;

    // Counter: 9 enabled cycles -> 1..7,0,1; encode 0xB in the first of them
    enc_req(4'hB);
    step();
    chk("enc_0xB_const", 32'(enc_code_out), 32'h55);
    step();
    chk("enc_0xB_hold", 32'(enc_code_out), 32'h55);
    // Back-to-back corner encodes
    enc_req(4'h0);
    step();
    enc_req(4'hF);
    step();
    chk("enc_0xF_const", 32'(enc_code_out), 32'h7F);
    repeat (5) step();
    cnt_ena = 1'b0;
    repeat (3) step();

    // Decode clean and single-error reference words
    dec_req(7'h55, 4'hB, 3'd0);
    step();
    dec_req(7'h45, 4'hB, 3'd5);
    step();
    chk("dec_0x45_syn_const", 32'(dec_syndrome_out), 32'd5);
    step();

    // Sweep every nibble with every single-bit flip, overlapping encodes and counting
    cnt_ena = 1'b1;
    for (int unsigned d = 0; d < 16; d++) begin
      for (int unsigned b = 0; b < 7; b++) begin
        c = model_encode(4'(d));
        c[b] = ~c[b];
        dec_req(c, 4'(d), 3'(b + 1));
        if (b == 0) enc_req(4'(d));
        step();
      end
    end
    cnt_ena = 1'b0;
    step();

    // Mid-stream reset: pending requests dropped; counter reset at 5
    cnt_ena = 1'b1;
    while (m_cnt != 3'd5) step();
    enc_req(4'h6);
    dec_req(7'h55, 4'hB, 3'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_ena = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
